dmem_unit: RTL

- Data-memory block directly downstream of the memory-access (MA) stage.
- Consumes the MA stage's effective address (ALU result), store data (MDR) and load/store controls; returns load data to the MA stage.
- Fixed multi-cycle access latency. Raises a stall (busy) so the pipeline holds the MA instruction until the response arrives.
- Word-organised, 32-bit data, byte addresses on the interface.

---
 rtl/dmem_unit.sv | 93 +++++++++
 1 files changed

// File: rtl/dmem_unit.sv
// Word-organised data memory behind the MA stage: fixed LATENCY+1 cycle access, response pulse in RESP.
// busy holds the pipeline from request acceptance until RESP; requests are not accepted in RESP.
module dmem_unit #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        rsp_valid,
  output logic [31:0] rd_data,
  output logic        addr_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic [3:0]         cnt;
  logic               we_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        mem [DEPTH];
  logic [ADDR_W-1:0]  idx;
  logic               err;
  logic               access;

  // Decode works only from the captured request so inputs may change while waiting.
  assign idx    = addr_q[ADDR_W+1:2];
  assign err    = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_W + 2)) != 32'd0);
  assign access = (state == WAIT) && (cnt == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          busy      = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (cnt == 4'd0) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rsp_valid <= 1'b0;
      addr_err  <= 1'b0;
      rd_data   <= 32'd0;
    end else begin
      rsp_valid <= access;
      addr_err  <= access && err;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt     <= 4'(LATENCY - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        if (err)        rd_data <= 32'd0;
        else if (!we_q) rd_data <= mem[idx];
      end
    end
  end

  // Array is never cleared; a reset landing on the access edge must still block the write.
  always_ff @(posedge clk) begin
    if (!reset && access && we_q && !err) mem[idx] <= wdata_q;
  end

endmodule
